instr_reg_multiword: RTL and testbench

//  Parametrised instruction register for the SAP-class CPU. Captures instruction

---
 rtl/instr_reg_multiword.sv | 58 +++++
 tb/tb_instr_reg_multiword.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_reg_multiword.sv
// instr_reg_multiword: bus-fed instruction register splitting single- and two-word instructions into opcode and operand
module instr_reg_multiword #(
  parameter int BUS_W = 8,
  parameter int OPC_W = 4,
  parameter logic [2**OPC_W-1:0] LONG_MASK = 16'h0C00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_en,
  input  logic [BUS_W-1:0] bus_in,
  input  logic             send_en,
  output logic [OPC_W-1:0] opcode,
  output logic [BUS_W-1:0] operand,
  output logic [BUS_W-1:0] operand_out,
  output logic             valid,
  output logic             need_word,
  output logic             send_err
);
  typedef enum logic [1:0] {EMPTY, WAIT_OPR, FULL} state_t;
  state_t state_q;
  logic [OPC_W-1:0] opcode_q;
  logic [BUS_W-1:0] operand_q;
  logic send_err_q;
  logic [OPC_W-1:0] bus_opc;
  assign bus_opc = bus_in[BUS_W-1 -: OPC_W];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      opcode_q <= '0;
      operand_q <= '0;
      send_err_q <= 1'b0;
    end else if (clr) begin
      state_q <= EMPTY;
      opcode_q <= '0;
      operand_q <= '0;
      send_err_q <= 1'b0;
    end else begin
      send_err_q <= send_en && (state_q != FULL);
      if (load_en) begin
        if (state_q == WAIT_OPR) begin
          operand_q <= bus_in;
          state_q <= FULL;
        end else begin
          opcode_q <= bus_opc;
          state_q <= LONG_MASK[bus_opc] ? WAIT_OPR : FULL;
          operand_q <= LONG_MASK[bus_opc] ? '0 : {{OPC_W{1'b0}}, bus_in[BUS_W-OPC_W-1:0]};
        end
      end
    end
  end
  assign opcode = opcode_q;
  assign operand = operand_q;
  assign valid = (state_q == FULL);
  assign need_word = (state_q == WAIT_OPR);
  assign send_err = send_err_q;
  assign operand_out = (send_en && valid) ? operand_q : '0;
endmodule

// File: tb/tb_instr_reg_multiword.sv
// tb_instr_reg_multiword: randomized and directed check of instr_reg_multiword against an instruction-level model
module tb_instr_reg_multiword;
  logic clk = 1'b0;
  logic rst, clr, load_en, send_en;
  logic [7:0] bus_in;
  logic [3:0] opcode;
  logic [7:0] operand, operand_out;
  logic valid, need_word, send_err;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] long_ops = 16'h0C00;
  logic [3:0] m_op;
  logic [7:0] m_opr;
  logic m_valid, m_need, m_err;
  instr_reg_multiword dut (
    .clk(clk), .rst(rst), .clr(clr), .load_en(load_en), .bus_in(bus_in),
    .send_en(send_en), .opcode(opcode), .operand(operand),
    .operand_out(operand_out), .valid(valid), .need_word(need_word),
    .send_err(send_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_op = 0;
    m_opr = 0;
    m_valid = 0;
    m_need = 0;
    m_err = 0;
  endtask
  task automatic check_all();
    chk("opcode", opcode, m_op);
    chk("operand", operand, m_opr);
    chk("valid", valid, m_valid);
    chk("need_word", need_word, m_need);
    chk("send_err", send_err, m_err);
    chk("operand_out", operand_out, (send_en && m_valid) ? m_opr : 8'h00);
  endtask
  task automatic cyc(input logic c, input logic l, input logic s, input logic [7:0] b);
    clr = c;
    load_en = l;
    send_en = s;
    bus_in = b;
    @(posedge clk);
    if (c) model_reset();
    else begin
      m_err = s && !m_valid;
      if (l) begin
        if (m_need) begin
          m_opr = b;
          m_need = 0;
          m_valid = 1;
        end else begin
          m_op = b[7:4];
          m_need = long_ops[b[7:4]];
          m_valid = !m_need;
          m_opr = m_need ? 8'h00 : {4'h0, b[3:0]};
        end
      end
    end
    #1 check_all();
  endtask
  task automatic async_rst();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    clr = 0;
    load_en = 0;
    send_en = 0;
    bus_in = 0;
    model_reset();
    #12 rst = 1'b0;
    check_all();
    cyc(0, 1, 0, 8'h1E);
    chk("short_opcode", opcode, 4'h1);
    chk("short_operand", operand, 8'h0E);
    send_en = 1;
    #1 chk("send_on", operand_out, 8'h0E);
    send_en = 0;
    #1 chk("send_off", operand_out, 8'h00);
    async_rst();
    chk("rst_valid", valid, 1'b0);
    cyc(0, 1, 0, 8'hA3);
    chk("long_need", need_word, 1'b1);
    chk("long_opr0", operand, 8'h00);
    cyc(0, 1, 0, 8'h5C);
    chk("long_opcode", opcode, 4'hA);
    chk("long_operand", operand, 8'h5C);
    cyc(0, 1, 0, 8'hB0);
    async_rst();
    cyc(0, 1, 0, 8'hB0);
    cyc(1, 1, 0, 8'h22);
    chk("clr_valid", valid, 1'b0);
    chk("clr_opcode", opcode, 4'h0);
    cyc(0, 1, 0, 8'h1E);
    cyc(0, 1, 1, 8'h47);
    chk("reload_opcode", opcode, 4'h4);
    chk("reload_operand", operand, 8'h07);
    cyc(0, 0, 0, 8'hFF);
    cyc(0, 0, 0, 8'hA5);
    chk("hold_operand", operand, 8'h07);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    chk("err_pulse", send_err, 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk("err_clear", send_err, 1'b0);
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 2) == 0) ? {3'b101, 1'($urandom_range(0, 1)), 4'($urandom)} : 8'($urandom));
      if ($urandom_range(0, 39) == 0) async_rst();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
